// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered -- buffered 8N1 UART transmitter.
//
// Bytes written through wr_en/wr_data are queued in a circular FIFO. A frame
// FSM pops them one at a time and shifts them out LSB first at DIV = CLK_FREQ/BAUD
// clocks per bit. Back-to-back bytes are sent with no idle gap between frames.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : even-parity bit (^byte) inserted between data and stop (11 bits/frame)
//   undefined : plain 8N1 (10 bits/frame)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high; discards queued data, aborts frame
//   wr_en    in   push wr_data this cycle (dropped when full)
//   wr_data  in   byte to queue
//   full     out  FIFO holds FIFO_DEPTH entries (registered)
//   empty    out  FIFO holds no entries (registered)
//   count    out  FIFO occupancy (registered)
//   tx_busy  out  frame FSM not idle (registered)
//   tx       out  serial line, idle high, driven from a flop
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        tx_busy,
  output logic                        tx
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  logic               push;
  logic               pop;
  logic               bit_end;

  // Frame FSM, FIFO bookkeeping and line outputs. tx/tx_busy are computed from
  // the next state so they change on the same edge as the state register.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif

    push    = wr_en && !full_q;
    bit_end = (baud_q == CNT_W'(DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == OCC_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);

    case (state_d)
      S_START:    tx_d = 1'b0;
      S_DATA:     tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY:   tx_d = par_d;
`endif
      default:    tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;
  assign tx_busy = busy_q;
  assign tx      = tx_q;

endmodule
